// File: rtl/ps2_pkg.sv
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared types, constants and parity helper for the PS/2 receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    // Parity bit that makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_filter.sv
// ============================================================================
// Module : ps2_rx_filter
// Brief  : Line synchroniser, PS/2 clock glitch filter, falling-edge strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_rx_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    localparam int CW = $clog2(FILTER_LEN);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_filt;
    logic          r_filt_d;
    logic [CW-1:0] r_cnt;

    // The filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_filt      <= 1'b1;
            r_filt_d    <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_filt_d    <= r_filt;
            if (r_clk_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign fall   = r_filt_d & ~r_filt;
    assign data_s = r_data_sync[1];

endmodule

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module : ps2_rx
// Brief  : PS/2 device-to-host frame receiver with show-ahead byte FIFO.
//          Optional E0/F0 prefix folding under macro PS2_RX_EXT_DECODE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 25000,
    parameter int FIFO_BITS  = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    output logic       valid,
    output logic [7:0] dout,
    output logic       ext,
    output logic       brk,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 1 << FIFO_BITS;
`ifdef PS2_RX_EXT_DECODE_EN
    localparam int ENTRY_W = 10;
`else
    localparam int ENTRY_W = 8;
`endif

    logic w_fall;
    logic w_data_s;

    ps2_rx_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (w_fall),
        .data_s   (w_data_s)
    );

    ps2_state_t r_state, w_state_next;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_par, w_par_next;
    logic [TW-1:0] r_to_cnt;
    logic       w_timeout;
    logic       w_push_req;
    logic       w_perr;
    logic       w_ferr;
    logic       r_parity_err;
    logic       r_frame_err;

    assign w_timeout = (r_state != IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_par        <= 1'b0;
            r_to_cnt     <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_shift      <= w_shift_next;
            r_par        <= w_par_next;
            r_parity_err <= w_perr;
            r_frame_err  <= w_ferr;
            if (w_fall || r_state == IDLE) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TW'(TIMEOUT)) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_par_next     = r_par;
        w_push_req     = 1'b0;
        w_perr         = 1'b0;
        w_ferr         = 1'b0;
        if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (!w_data_s) begin
                        w_state_next   = DATA;
                        w_bit_cnt_next = 3'd0;
                    end
                end
                DATA: begin
                    w_shift_next[r_bit_cnt] = w_data_s;
                    w_bit_cnt_next          = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = PARITY;
                    end
                end
                PARITY: begin
                    w_par_next   = w_data_s;
                    w_state_next = STOP;
                end
                STOP: begin
                    w_state_next = IDLE;
                    // Parity is judged before the stop bit.
                    if (r_par != odd_parity(r_shift)) begin
                        w_perr = 1'b1;
                    end else if (!w_data_s) begin
                        w_ferr = 1'b1;
                    end else begin
                        w_push_req = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end else if (w_timeout) begin
            w_ferr       = 1'b1;
            w_state_next = IDLE;
        end
    end

    logic               w_push;
    logic [ENTRY_W-1:0] w_entry;

`ifdef PS2_RX_EXT_DECODE_EN
    logic r_pend_ext;
    logic r_pend_brk;
    logic w_is_ext;
    logic w_is_brk;

    assign w_is_ext = (r_shift == PS2_EXT_PREFIX);
    assign w_is_brk = (r_shift == PS2_BRK_PREFIX);
    assign w_push   = w_push_req && !w_is_ext && !w_is_brk;
    assign w_entry  = {r_pend_ext, r_pend_brk, r_shift};

    always_ff @(posedge clk_sys) begin
        if (reset || w_perr || w_ferr) begin
            r_pend_ext <= 1'b0;
            r_pend_brk <= 1'b0;
        end else if (w_push_req) begin
            if (w_is_ext) begin
                r_pend_ext <= 1'b1;
            end else if (w_is_brk) begin
                r_pend_brk <= 1'b1;
            end else begin
                r_pend_ext <= 1'b0;
                r_pend_brk <= 1'b0;
            end
        end
    end
`else
    assign w_push  = w_push_req;
    assign w_entry = r_shift;
`endif

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [FIFO_BITS:0] r_wr_ptr;
    logic [FIFO_BITS:0] r_rd_ptr;
    logic               r_overflow;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;
    logic [ENTRY_W-1:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_BITS] != r_rd_ptr[FIFO_BITS]) &&
                     (r_wr_ptr[FIFO_BITS-1:0] == r_rd_ptr[FIFO_BITS-1:0]);
    assign w_pop   = rd && !w_empty;
    // A simultaneous pop frees the slot the push lands in.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr[FIFO_BITS-1:0]];

    always_ff @(posedge clk_sys) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[FIFO_BITS-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (FIFO_BITS+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (FIFO_BITS+1)'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign valid      = !w_empty;
    assign dout       = valid ? w_head[7:0] : 8'h00;
`ifdef PS2_RX_EXT_DECODE_EN
    assign ext        = valid & w_head[9];
    assign brk        = valid & w_head[8];
`else
    assign ext        = 1'b0;
    assign brk        = 1'b0;
`endif
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx.sv
// ============================================================================
// Module : tb_ps2_rx
// Brief  : Directed self-checking bench for ps2_rx.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 25000;
    localparam int FIFO_BITS  = 3;
    localparam int HALF_SLOW  = 400;
    localparam int HALF_FAST  = 40;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd       = 1'b0;
    logic       valid;
    logic [7:0] dout;
    logic       ext;
    logic       brk;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int n_cmp    = 0;
    int n_bad    = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int lat_seen = 0;
    int lat1     = 0;
    int p0, f0;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT),
        .FIFO_BITS  (FIFO_BITS)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd         (rd),
        .valid      (valid),
        .dout       (dout),
        .ext        (ext),
        .brk        (brk),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // Counting high cycles (not edges) also catches pulses longer than one cycle.
    always @(negedge clk_sys) begin
        if (parity_err) perr_cnt++;
        if (frame_err)  ferr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One PS/2 bit: data set while the clock is high, then a low half-period.
    // rd is pulsed for one cycle starting rd_at cycles after the falling edge.
    task automatic ps2_bit(input logic b, input int half, input int rd_at);
        ps2_data = b;
        repeat (half) @(negedge clk_sys);
        ps2_clk  = 1'b0;
        lat_seen = 0;
        for (int i = 1; i <= half; i++) begin
            @(negedge clk_sys);
            if (lat_seen == 0 && valid) lat_seen = i;
            if (i == rd_at) rd = 1'b1;
            else if (i == rd_at + 1) rd = 1'b0;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int half, input int rd_at);
        ps2_bit(1'b0, half, -2);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], half, -2);
        ps2_bit(par, half, -2);
        ps2_bit(stop, half, rd_at);
        ps2_data = 1'b1;
        repeat (half) @(negedge clk_sys);
    endtask

    task automatic send_good(input logic [7:0] b, input int half, input int rd_at);
        send_frame(b, ~^b, 1'b1, half, rd_at);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_eq({tag, " valid"}, valid, 1);
        check_eq({tag, " dout"}, dout, exp);
        rd = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(negedge clk_sys);
        check_eq("rst valid", valid, 0);
        check_eq("rst dout", dout, 0);
        check_eq("rst ext", ext, 0);
        check_eq("rst brk", brk, 0);
        check_eq("rst parity_err", parity_err, 0);
        check_eq("rst frame_err", frame_err, 0);
        check_eq("rst overflow", overflow, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk_sys);

        // Basic frame at the slow bit rate
        send_good(8'h1C, HALF_SLOW, -2);
        lat1 = lat_seen;
        check_eq("t1 latency window", (lat1 >= 3 && lat1 <= FILTER_LEN + 8), 1);
        pop_check("t1", 8'h1C);
        check_eq("t1 empty after rd", valid, 0);

        // Bad parity dropped, next frame fine
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, HALF_FAST, -2);
        repeat (10) @(negedge clk_sys);
        check_eq("t2 parity_err pulses", perr_cnt - p0, 1);
        check_eq("t2 frame_err pulses", ferr_cnt - f0, 0);
        check_eq("t2 nothing pushed", valid, 0);
        send_good(8'h29, HALF_FAST, -2);
        pop_check("t2", 8'h29);

        // Truncated frame abandoned by timeout
        p0 = perr_cnt; f0 = ferr_cnt;
        ps2_bit(1'b0, HALF_FAST, -2);
        ps2_bit(1'b1, HALF_FAST, -2);
        ps2_bit(1'b0, HALF_FAST, -2);
        ps2_bit(1'b1, HALF_FAST, -2);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 10) @(negedge clk_sys);
        check_eq("t3 frame_err pulses", ferr_cnt - f0, 1);
        check_eq("t3 parity_err pulses", perr_cnt - p0, 0);
        check_eq("t3 nothing pushed", valid, 0);
        send_good(8'h5A, HALF_FAST, -2);
        pop_check("t3", 8'h5A);

        // Short clock glitch in IDLE with data low is filtered out
        p0 = perr_cnt; f0 = ferr_cnt;
        ps2_data = 1'b0;
        repeat (20) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk_sys);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk_sys);
        send_good(8'h1C, HALF_FAST, -2);
        check_eq("t4 no errors", (perr_cnt - p0) + (ferr_cnt - f0), 0);
        pop_check("t4", 8'h1C);
        check_eq("t4 empty", valid, 0);

        // Fill, push-while-full with pop, then overflow
        for (int b = 1; b <= 8; b++) send_good(8'(b), HALF_FAST, -2);
        check_eq("t5 full no overflow", overflow, 0);
        send_good(8'h09, HALF_FAST, lat1 - 1);
        check_eq("t5 push+pop no overflow", overflow, 0);
        send_good(8'h0A, HALF_FAST, -2);
        check_eq("t5 overflow set", overflow, 1);
        for (int b = 2; b <= 9; b++) pop_check("t5 pop", 8'(b));
        check_eq("t5 drained", valid, 0);
        check_eq("t5 overflow sticky", overflow, 1);

`ifdef PS2_RX_EXT_DECODE_EN
        send_good(8'hE0, HALF_FAST, -2);
        send_good(8'hF0, HALF_FAST, -2);
        send_good(8'h75, HALF_FAST, -2);
        check_eq("t6 ext", ext, 1);
        check_eq("t6 brk", brk, 1);
        pop_check("t6", 8'h75);
        check_eq("t6 single entry", valid, 0);
        send_good(8'h75, HALF_FAST, -2);
        check_eq("t6 plain ext", ext, 0);
        check_eq("t6 plain brk", brk, 0);
        pop_check("t6 plain", 8'h75);
`else
        send_good(8'hE0, HALF_FAST, -2);
        check_eq("t6 raw ext", ext, 0);
        check_eq("t6 raw brk", brk, 0);
        pop_check("t6 raw", 8'hE0);
        check_eq("t6 empty", valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
